// File: rtl/spart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : spart_tx
//  Purpose  : SPART transmitter. One-entry holding buffer written over the
//             processor I/O bus, separate shift register, 8N1 framing on txd
//             timed by the oversampled baud tick from the baud generator.
//  Revision : 1.0 - initial release
// ============================================================================
module spart_tx #(
  parameter int         OVERSAMPLE = 16,
  parameter logic [1:0] TX_ADDR    = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data_bus,
  input  logic [1:0] ioaddr,
  input  logic       iocs,
  input  logic       iorw,
  output logic       txd,
  output logic       tbr
);

  // Counter only needs to reach OVERSAMPLE-1, so clog2 bits never overflow.
  localparam int              TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        hold_buf;
  logic              buf_full;
  logic              write_acc;
  logic              bit_end;
  logic              load;

  // A write is only taken while the holding buffer is empty.
  assign write_acc = iocs && !iorw && (ioaddr == TX_ADDR) && !buf_full;

  // Baud ticks are ignored while idle; a bit ends on its last tick.
  assign bit_end = enable && (state != IDLE) && (tick_cnt == TICK_LAST);

  // Buffer moves into the shift register when idle, or back-to-back at the
  // end of a stop bit so queued bytes follow with no idle gap.
  assign load = buf_full && ((state == IDLE) || ((state == STOP) && bit_end));

  assign tbr = ~buf_full;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (buf_full) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_cnt == 3'd7)) state_next = STOP;
      STOP:    if (bit_end) state_next = buf_full ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line level decoded from state so reset forces idle-high without a clock.
  always_comb begin
    txd = 1'b1;
    case (state)
      IDLE:    txd = 1'b1;
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      STOP:    txd = 1'b1;
      default: txd = 1'b1;
    endcase
  end

  // Tick counter: counts baud ticks within the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (load) begin
      tick_cnt <= '0;
    end else if ((state != IDLE) && enable) begin
      tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
    end
  end

  // Bit counter: position within the eight data bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0;
    end else if (load) begin
      bit_cnt <= 3'd0;
    end else if ((state == DATA) && bit_end) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Shift register: loaded from the buffer, shifted right so LSB goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= 8'h00;
    end else if (load) begin
      shreg <= hold_buf;
    end else if ((state == DATA) && bit_end) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  // Holding buffer data: written only by an accepted bus write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_buf <= 8'h00;
    end else if (write_acc) begin
      hold_buf <= data_bus;
    end
  end

  // Holding buffer flag: load and accept never coincide since they need
  // opposite buffer states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full <= 1'b0;
    end else if (load) begin
      buf_full <= 1'b0;
    end else if (write_acc) begin
      buf_full <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spart_tx
//  Purpose  : Self-checking bench for spart_tx. A frame-level reference model
//             (frame position in ticks, queued byte) predicts txd and tbr.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spart_tx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] data_bus;
  logic [1:0] ioaddr;
  logic       iocs;
  logic       iorw;
  logic       txd;
  logic       tbr;

  int checks = 0;
  int errors = 0;

  // Reference model state: frame in progress, ticks elapsed in frame,
  // byte on the line, and the single queued byte.
  logic       m_busy;
  int         m_pos;
  logic [7:0] m_byte;
  logic       m_q_full;
  logic [7:0] m_q_byte;

  typedef struct {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    logic       exp_tbr;
  } vec_t;

  vec_t vecs[6];

  spart_tx #(.OVERSAMPLE(OS), .TX_ADDR(2'b00)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .data_bus (data_bus),
    .ioaddr   (ioaddr),
    .iocs     (iocs),
    .iorw     (iorw),
    .txd      (txd),
    .tbr      (tbr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / OS;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_pos    = 0;
    m_byte   = 8'h00;
    m_q_full = 1'b0;
    m_q_byte = 8'h00;
  endtask

  // One clock edge of the model, using the inputs that were present before it.
  task automatic model_edge(input logic en, input logic cs, input logic rw,
                            input logic [1:0] a, input logic [7:0] d);
    logic acc;
    acc = cs && !rw && (a == 2'b00) && !m_q_full;
    if (m_busy) begin
      if (en) begin
        if (m_pos == 10*OS - 1) begin
          if (m_q_full) begin
            m_byte   = m_q_byte;
            m_q_full = 1'b0;
            m_pos    = 0;
          end else begin
            m_busy = 1'b0;
            m_pos  = 0;
          end
        end else begin
          m_pos++;
        end
      end
    end else if (m_q_full) begin
      m_busy   = 1'b1;
      m_pos    = 0;
      m_byte   = m_q_byte;
      m_q_full = 1'b0;
    end
    if (acc) begin
      m_q_full = 1'b1;
      m_q_byte = d;
    end
  endtask

  // Drive inputs, take one edge, advance the model and compare after the edge.
  task automatic step(input logic en, input logic cs, input logic rw,
                      input logic [1:0] a, input logic [7:0] d);
    enable   = en;
    iocs     = cs;
    iorw     = rw;
    ioaddr   = a;
    data_bus = d;
    @(posedge clk);
    model_edge(en, cs, rw, a, d);
    #1;
    check("model_txd", txd, model_txd());
    check("model_tbr", tbr, !m_q_full);
  endtask

  task automatic idle_steps(input int n, input int period);
    for (int i = 0; i < n; i++) step((i % period) == 0, 1'b0, 1'b0, 2'b00, 8'($urandom));
  endtask

  // Reset pulse placed between clock edges to show txd returns high at once.
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_txd_async", txd, 1'b1);
    check("rst_tbr_async", tbr, 1'b1);
    #2 rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{cs: 1'b1, rw: 1'b1, addr: 2'b00, data: 8'h5A, exp_tbr: 1'b1};
    vecs[1] = '{cs: 1'b1, rw: 1'b0, addr: 2'b01, data: 8'h11, exp_tbr: 1'b1};
    vecs[2] = '{cs: 1'b1, rw: 1'b0, addr: 2'b10, data: 8'h22, exp_tbr: 1'b1};
    vecs[3] = '{cs: 1'b1, rw: 1'b0, addr: 2'b11, data: 8'h33, exp_tbr: 1'b1};
    vecs[4] = '{cs: 1'b0, rw: 1'b0, addr: 2'b00, data: 8'h44, exp_tbr: 1'b1};
    vecs[5] = '{cs: 1'b1, rw: 1'b0, addr: 2'b00, data: 8'h96, exp_tbr: 1'b0};

    rst = 1'b1; enable = 1'b0; data_bus = 8'h00; ioaddr = 2'b00; iocs = 1'b0; iorw = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_txd", txd, 1'b1);
    check("reset_tbr", tbr, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Idle line with enable tied high.
    idle_steps(200, 1);

    // Single frame 0xA5: tbr low exactly one cycle, start bit right after.
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
    check("a5_tbr_after_write", tbr, 1'b0);
    check("a5_txd_still_idle", txd, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    check("a5_tbr_freed", tbr, 1'b1);
    check("a5_start_bit", txd, 1'b0);
    idle_steps(170, 1);

    // Back-to-back 0x3C / 0xC3 with a dropped 0xFF while the buffer is full.
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'h3C);
    idle_steps(20, 1);
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'hC3);
    idle_steps(5, 1);
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'hFF);
    check("drop_tbr_still_low", tbr, 1'b0);
    idle_steps(340, 1);
    check("b2b_back_to_idle", txd, 1'b1);

    // Slow baud: enable every 4th cycle, byte 0x01.
    step(1'b0, 1'b1, 1'b0, 2'b00, 8'h01);
    idle_steps(10*OS*4 + 40, 4);

    // Address/direction decode table; the accepted write is drained afterward.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].cs, vecs[i].rw, vecs[i].addr, vecs[i].data);
      check("decode_tbr", tbr, vecs[i].exp_tbr);
      idle_steps(170, 1);
    end

    // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0, line low).
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
    for (int i = 0; i < 200 && !(m_busy && m_pos == 4*OS + 8); i++)
      step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    check("pre_rst_txd_low", txd, 1'b0);
    async_reset_pulse();
    idle_steps(20, 1);
    check("post_rst_idle", txd, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'h55);
    idle_steps(170, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       en;
      logic       cs;
      en = ($urandom_range(0, 2) != 0);
      cs = ($urandom_range(0, 7) == 0);
      step(en, cs, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
